axi_rd_arbiter: RTL and testbench

Two-master AXI read-channel arbiter that shares one AXI slave's AR/R channels between two requesters (DMAC read engines, or the bench masters in front of the AXI slave memory model). It grants one master at a time, forwards its AR beat to the slave, routes the whole R burst back to that master, and rotates priority after every completed burst. Only one read is outstanding at the slave at any time.

---
 rtl/axi_rd_arbiter.sv | 155 +++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI read arbiter: one read outstanding at the shared slave,
// grant held from AR acceptance through the R burst's rlast, priority rotates per burst.
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

module axi_rd_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = `AXI_DATA_WIDTH,
  parameter int ID_WIDTH   = `AXI_ID_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  input  logic [ADDR_WIDTH-1:0] m0_araddr,
  input  logic [ID_WIDTH-1:0]   m0_arid,
  input  logic [3:0]            m0_arlen,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [ID_WIDTH-1:0]   m0_rid,
  output logic [1:0]            m0_rresp,
  output logic                  m0_rlast,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  input  logic [ADDR_WIDTH-1:0] m1_araddr,
  input  logic [ID_WIDTH-1:0]   m1_arid,
  input  logic [3:0]            m1_arlen,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ID_WIDTH-1:0]   m1_rid,
  output logic [1:0]            m1_rresp,
  output logic                  m1_rlast,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  output logic [ADDR_WIDTH-1:0] s_araddr,
  output logic [ID_WIDTH-1:0]   s_arid,
  output logic [3:0]            s_arlen,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [ID_WIDTH-1:0]   s_rid,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rlast,
  output logic                  busy,
  output logic                  grant
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       grant_q, grant_d;
  logic       prio_q, prio_d;
  logic [1:0] req;
  logic       win;

  assign req = {m1_arvalid, m0_arvalid};
  // The prio master wins if it is requesting; otherwise the only requester does.
  assign win = req[prio_q] ? prio_q : ~prio_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    prio_d     = prio_q;
    s_arvalid  = 1'b0;
    s_araddr   = '0;
    s_arid     = '0;
    s_arlen    = '0;
    s_rready   = 1'b0;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rdata   = '0;
    m0_rid     = '0;
    m0_rresp   = '0;
    m0_rlast   = 1'b0;
    m1_rvalid  = 1'b0;
    m1_rdata   = '0;
    m1_rid     = '0;
    m1_rresp   = '0;
    m1_rlast   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          grant_d = win;
          state_d = S_AR;
        end
      end
      S_AR: begin
        if (grant_q) begin
          s_arvalid  = m1_arvalid;
          s_araddr   = m1_araddr;
          s_arid     = m1_arid;
          s_arlen    = m1_arlen;
          m1_arready = s_arready;
        end else begin
          s_arvalid  = m0_arvalid;
          s_araddr   = m0_araddr;
          s_arid     = m0_arid;
          s_arlen    = m0_arlen;
          m0_arready = s_arready;
        end
        if (s_arvalid && s_arready) state_d = S_R;
      end
      S_R: begin
        if (grant_q) begin
          m1_rvalid = s_rvalid;
          m1_rdata  = s_rdata;
          m1_rid    = s_rid;
          m1_rresp  = s_rresp;
          m1_rlast  = s_rlast;
          s_rready  = m1_rready;
        end else begin
          m0_rvalid = s_rvalid;
          m0_rdata  = s_rdata;
          m0_rid    = s_rid;
          m0_rresp  = s_rresp;
          m0_rlast  = s_rlast;
          s_rready  = m0_rready;
        end
        // Burst end comes from the slave's rlast only; arlen is never counted here.
        if (s_rvalid && s_rready && s_rlast) begin
          prio_d  = ~grant_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy  = (state_q != S_IDLE);
  assign grant = grant_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: master/slave bus models, per-master beat scoreboard,
// and a grant-order queue derived from the alternating-priority rule.
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

module tb_axi_rd_arbiter;
  localparam int AW = 16;
  localparam int DW = `AXI_DATA_WIDTH;
  localparam int IW = `AXI_ID_WIDTH;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
    logic [3:0]    len;
  } req_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic [1:0]    resp;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]    m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [AW-1:0] m_araddr [2];
  logic [IW-1:0] m_arid [2];
  logic [3:0]    m_arlen [2];
  logic [DW-1:0] m_rdata [2];
  logic [IW-1:0] m_rid [2];
  logic [1:0]    m_rresp [2];
  logic          s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [AW-1:0] s_araddr;
  logic [IW-1:0] s_arid, s_rid;
  logic [3:0]    s_arlen;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic          busy, grant;

  axi_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_arvalid(m_arvalid[0]), .m0_arready(m_arready[0]), .m0_araddr(m_araddr[0]),
    .m0_arid(m_arid[0]), .m0_arlen(m_arlen[0]),
    .m0_rvalid(m_rvalid[0]), .m0_rready(m_rready[0]), .m0_rdata(m_rdata[0]),
    .m0_rid(m_rid[0]), .m0_rresp(m_rresp[0]), .m0_rlast(m_rlast[0]),
    .m1_arvalid(m_arvalid[1]), .m1_arready(m_arready[1]), .m1_araddr(m_araddr[1]),
    .m1_arid(m_arid[1]), .m1_arlen(m_arlen[1]),
    .m1_rvalid(m_rvalid[1]), .m1_rready(m_rready[1]), .m1_rdata(m_rdata[1]),
    .m1_rid(m_rid[1]), .m1_rresp(m_rresp[1]), .m1_rlast(m_rlast[1]),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arid(s_arid), .s_arlen(s_arlen),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rid(s_rid), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .busy(busy), .grant(grant)
  );

  req_t  req_q [2][$];
  req_t  iss_q [2][$];
  beat_t exp_r [2][$];
  int    exp_order [$];
  int    rr_mode [2];
  int    rcv_cnt [2];
  int    n_chk = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    last_rlast_cyc = -100;
  int    id_seq = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Slave memory contents: each beat is a pure function of the request and beat index.
  function automatic beat_t mk_beat(req_t r, int b);
    beat_t t;
    t.data = {r.addr, 4'h0, r.id, 8'(b)};
    t.id   = r.id;
    t.resp = 2'(b);
    t.last = (b == int'(r.len));
    return t;
  endfunction

  task automatic push_req(int m, logic [AW-1:0] a, logic [3:0] len);
    req_t r;
    id_seq++;
    r.addr = a;
    r.len  = len;
    r.id   = {1'(m), 3'(id_seq)};
    req_q[m].push_back(r);
  endtask

  task automatic flush_all();
    exp_order.delete();
    for (int m = 0; m < 2; m++) begin
      req_q[m].delete();
      iss_q[m].delete();
      exp_r[m].delete();
    end
  endtask

  task automatic wait_done(int budget);
    int k = 0;
    while (k < budget && !(req_q[0].size() == 0 && req_q[1].size() == 0 &&
           exp_r[0].size() == 0 && exp_r[1].size() == 0 && exp_order.size() == 0 &&
           m_arvalid == 2'b00 && !busy)) begin
      @(negedge clk); #1;
      k++;
    end
    chk("done_in_budget", 64'(k < budget), 64'd1);
    if (k >= budget) flush_all();
  endtask

  task automatic wait_rcv(int m, int n);
    int k = 0;
    while (rcv_cnt[m] < n && k < 500) begin
      @(negedge clk); #1;
      k++;
    end
    chk("rcv_in_budget", 64'(rcv_cnt[m] >= n), 64'd1);
  endtask

  task automatic chk_reset_outputs(string name);
    chk(name, 64'({busy, grant, s_arvalid, s_rready, m_arready, m_rvalid, m_rlast}), 64'd0);
  endtask

  // Bus models and monitors: sample at negedge, drive 1 time unit after posedge.
  initial begin : bfm
    logic [1:0] ar_hs;
    logic       s_ar_hs, s_r_hs, prev_s_arvalid, slv_busy;
    req_t       slv_req, r;
    beat_t      bt;
    int         sbeat, em;
    m_arvalid = '0;
    m_rready  = '0;
    for (int m = 0; m < 2; m++) begin
      m_araddr[m] = '0;
      m_arid[m]   = '0;
      m_arlen[m]  = '0;
    end
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rid = '0; s_rresp = '0; s_rlast = 1'b0;
    slv_busy = 1'b0; prev_s_arvalid = 1'b0; sbeat = 0; slv_req = '0;
    forever begin
      @(negedge clk);
      cyc++;
      ar_hs   = m_arvalid & m_arready;
      s_ar_hs = s_arvalid & s_arready;
      s_r_hs  = s_rvalid & s_rready;
      if (s_ar_hs) slv_req = '{s_araddr, s_arid, s_arlen};
      if (rst_n) begin
        chk("one_master_active", 64'((m_rvalid != 2'b11) && (m_arready != 2'b11)), 64'd1);
        for (int m = 0; m < 2; m++)
          if (!m_rvalid[m])
            chk("idle_r_fields_zero", 64'({m_rdata[m], m_rid[m], m_rresp[m], m_rlast[m]}), 64'd0);
        if (!s_arvalid) chk("idle_ar_fields_zero", 64'({s_araddr, s_arid, s_arlen}), 64'd0);
        if (s_arvalid && !prev_s_arvalid)
          chk("ar_gap_after_rlast", 64'((cyc - last_rlast_cyc) >= 2), 64'd1);
        if (s_ar_hs) begin
          chk("ar_order_expected", 64'(exp_order.size() > 0), 64'd1);
          if (exp_order.size() > 0) begin
            em = exp_order.pop_front();
            chk("ar_master", 64'(s_arid[IW-1]), 64'(em));
            chk("grant", 64'(grant), 64'(em));
            chk("ar_issued", 64'(iss_q[em].size() > 0), 64'd1);
            if (iss_q[em].size() > 0) begin
              r = iss_q[em].pop_front();
              chk("ar_fields", 64'({s_araddr, s_arid, s_arlen}), 64'({r.addr, r.id, r.len}));
            end
          end
        end
        for (int m = 0; m < 2; m++) begin
          if (m_rvalid[m] && m_rready[m]) begin
            rcv_cnt[m]++;
            chk("r_beat_expected", 64'(exp_r[m].size() > 0), 64'd1);
            if (exp_r[m].size() > 0) begin
              bt = exp_r[m].pop_front();
              chk("r_beat", 64'({m_rdata[m], m_rid[m], m_rresp[m], m_rlast[m]}), 64'(bt));
            end
          end
        end
        if (s_r_hs && s_rlast) last_rlast_cyc = cyc;
      end
      prev_s_arvalid = s_arvalid;

      @(posedge clk); #1;
      if (!rst_n) begin
        m_arvalid = '0;
        slv_busy  = 1'b0;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rid = '0; s_rresp = '0; s_rlast = 1'b0;
      end else begin
        for (int m = 0; m < 2; m++) begin
          if (ar_hs[m]) m_arvalid[m] = 1'b0;
          if (!m_arvalid[m] && req_q[m].size() > 0) begin
            r = req_q[m].pop_front();
            m_araddr[m]  = r.addr;
            m_arid[m]    = r.id;
            m_arlen[m]   = r.len;
            m_arvalid[m] = 1'b1;
            iss_q[m].push_back(r);
            for (int b = 0; b <= int'(r.len); b++) exp_r[m].push_back(mk_beat(r, b));
          end
          case (rr_mode[m])
            0:       m_rready[m] = 1'b1;
            1:       m_rready[m] = 1'($urandom_range(0, 1));
            default: m_rready[m] = 1'b0;
          endcase
        end
        if (s_ar_hs) begin
          slv_busy  = 1'b1;
          sbeat     = 0;
          s_arready = 1'b0;
        end else if (s_r_hs) begin
          if (s_rlast) slv_busy = 1'b0;
          else sbeat++;
        end
        if (slv_busy) begin
          if (!s_rvalid || s_r_hs) begin
            if ($urandom_range(0, 3) != 0) begin
              bt = mk_beat(slv_req, sbeat);
              s_rvalid = 1'b1; s_rdata = bt.data; s_rid = bt.id; s_rresp = bt.resp; s_rlast = bt.last;
            end else begin
              s_rvalid = 1'b0; s_rdata = '0; s_rid = '0; s_rresp = '0; s_rlast = 1'b0;
            end
          end
        end else begin
          s_rvalid = 1'b0; s_rdata = '0; s_rid = '0; s_rresp = '0; s_rlast = 1'b0;
          s_arready = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rr_mode[0] = 0; rr_mode[1] = 0;
    rcv_cnt[0] = 0; rcv_cnt[1] = 0;
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk_reset_outputs("reset_outputs");
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Simultaneous requests out of reset: prio starts at M0.
    #2;
    exp_order.push_back(0); exp_order.push_back(1);
    push_req(0, 16'h0000, 4'd2);
    push_req(1, 16'h1000, 4'd1);
    wait_done(1000);

    // Continuous load, arlen=1: strict alternation M0, M1, ...
    @(negedge clk); #2;
    for (int i = 0; i < 4; i++) begin
      push_req(0, 16'h0200 + 16'(i * 16), 4'd1);
      push_req(1, 16'h1200 + 16'(i * 16), 4'd1);
    end
    for (int i = 0; i < 8; i++) exp_order.push_back(i % 2);
    wait_done(2000);

    // M0 alone: one-cycle arbitration latency, fields forwarded unchanged.
    @(negedge clk); #2;
    exp_order.push_back(0);
    push_req(0, 16'h0100, 4'd3);
    @(negedge clk); #1;
    chk("lat_idle_cycle", 64'({busy, s_arvalid}), 64'd0);
    @(negedge clk); #1;
    chk("lat_ar_cycle", 64'({busy, grant, s_arvalid, s_araddr, s_arlen}),
        64'({1'b1, 1'b0, 1'b1, 16'h0100, 4'd3}));
    wait_done(1000);

    // After M0's burst prio is M1: simultaneous requests serve M1 first.
    @(negedge clk); #2;
    exp_order.push_back(1); exp_order.push_back(0);
    push_req(0, 16'h0400, 4'd0);
    push_req(1, 16'h1400, 4'd0);
    wait_done(1000);

    // M0 backpressure mid-burst while M1 waits.
    @(negedge clk); #2;
    rcv_cnt[0] = 0;
    exp_order.push_back(0); exp_order.push_back(1);
    push_req(0, 16'h2000, 4'd5);
    repeat (2) @(negedge clk);
    #2;
    push_req(1, 16'h2100, 4'd2);
    wait_rcv(0, 2);
    rr_mode[0] = 2;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("bp_hold", 64'({busy, grant, m_arready[1], s_rready}), 64'({1'b1, 1'b0, 1'b0, 1'b0}));
    end
    rr_mode[0] = 0;
    wait_done(1000);

    // Randomised continuous load: alternation from prio=M0 with random backpressure.
    @(negedge clk); #2;
    rr_mode[0] = 1; rr_mode[1] = 1;
    for (int i = 0; i < 5; i++) begin
      push_req(0, 16'($urandom) & 16'h7ff0, 4'($urandom_range(0, 7)));
      push_req(1, 16'($urandom) | 16'h8000, 4'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 10; i++) exp_order.push_back(i % 2);
    wait_done(4000);
    rr_mode[0] = 0; rr_mode[1] = 0;

    // Leave prio at M1, then reset in the middle of an arlen=7 burst.
    @(negedge clk); #2;
    exp_order.push_back(0);
    push_req(0, 16'h0500, 4'd0);
    wait_done(1000);
    @(negedge clk); #2;
    rcv_cnt[0] = 0;
    exp_order.push_back(0);
    push_req(0, 16'h3000, 4'd7);
    wait_rcv(0, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset_outputs");
    chk("async_reset_ar_fields", 64'({s_araddr, s_arid, s_arlen}), 64'd0);
    flush_all();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // prio restarts at M0 after reset, then a lone M1 request.
    #2;
    exp_order.push_back(0); exp_order.push_back(1);
    push_req(0, 16'h4000, 4'd1);
    push_req(1, 16'h5000, 4'd2);
    wait_done(1000);
    @(negedge clk); #2;
    exp_order.push_back(1);
    push_req(1, 16'h5100, 4'd3);
    wait_done(1000);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
